// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package restoring_divider_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_t;

endpackage

// File: rtl/restoring_divider_div_step.sv
// One shift / trial-subtract / select stage of the restoring divide loop.
module restoring_divider_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dmag_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {2'b00, dmag_i};
    // No borrow out of the top bit means the trial remainder is non-negative.
    q_bit_o = ~trial[WIDTH+1];
    rem_o   = q_bit_o ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Iterative signed/unsigned divider: one quotient bit per clock, quotient to LO, remainder to HI.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned        CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0]    CntMax  = CntW'(WIDTH);
  localparam logic [WIDTH-1:0]   AllOnes = {WIDTH{1'b1}};

  div_state_t       state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dmag_q;
  logic [WIDTH-1:0] orig_q;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             dvd_neg;
  logic             dsr_neg;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];

  restoring_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .dvd_msb_i(dvd_q[WIDTH-1]),
    .dmag_i   (dmag_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= StIdle;
      cnt         <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dmag_q      <= '0;
      orig_q      <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            dvd_q       <= dvd_neg ? -dividend : dividend;
            dmag_q      <= dsr_neg ? -divisor : divisor;
            orig_q      <= dividend;
            q_neg       <= dvd_neg ^ dsr_neg;
            r_neg       <= dvd_neg;
            rem_q       <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= StRun;
          end
        end
        StRun: begin
          // The counter reaches WIDTH only after the last iteration has retired.
          if (cnt == CntMax) begin
            state <= StFix;
          end else begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[WIDTH-2:0], step_q};
            cnt   <= cnt + 1'b1;
          end
        end
        StFix: begin
          if (dmag_q == '0) begin
            quotient    <= AllOnes;
            remainder   <= orig_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_neg ? -dvd_q : dvd_q;
            remainder   <= r_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= StDone;
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (WIDTH=32).
module tb_restoring_divider;

  localparam int unsigned W = 32;
  localparam int Lat = 34;

  logic         clock;
  logic         clear;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a one-cycle start; returns 1ns after the accepting edge.
  task automatic issue_start(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from the start edge until done is seen (bounded); also counts busy cycles.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) return;
      if (busy) busy_n++;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q got=%h want=0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r got=%h want=0", remainder); end
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, bn;
    issue_start(1'b0, 32'd100, 32'd7);
    wait_done(lat, bn);
    checks++; if (lat !== Lat) begin errors++; $display("FAIL u_latency got=%0d want=%0d", lat, Lat); end
    checks++; if (bn !== Lat) begin errors++; $display("FAIL u_busy_cycles got=%0d want=%0d", bn, Lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL u_busy_at_done got=%b want=0", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL u_q got=%h want=0000000e", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL u_r got=%h want=00000002", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL u_dbz got=%b want=0", div_by_zero); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL u_done_width got=%b want=0", done); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL u_q_held got=%h want=0000000e", quotient); end
  endtask

  task automatic test_signed();
    int lat, bn;
    logic [W-1:0] va [3] = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9};
    logic [W-1:0] vb [3] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [W-1:0] vq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    logic [W-1:0] vr [3] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      issue_start(1'b1, va[i], vb[i]);
      wait_done(lat, bn);
      checks++; if (lat !== Lat) begin errors++; $display("FAIL s_latency[%0d] got=%0d want=%0d", i, lat, Lat); end
      checks++; if (quotient !== vq[i]) begin errors++; $display("FAIL s_q[%0d] got=%h want=%h", i, quotient, vq[i]); end
      checks++; if (remainder !== vr[i]) begin errors++; $display("FAIL s_r[%0d] got=%h want=%h", i, remainder, vr[i]); end
      repeat (2) @(posedge clock);
    end
  endtask

  task automatic test_div_zero();
    int lat, bn;
    issue_start(1'b0, 32'd5, 32'd0);
    wait_done(lat, bn);
    checks++; if (lat !== Lat) begin errors++; $display("FAIL z_latency got=%0d want=%0d", lat, Lat); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL z_q got=%h want=ffffffff", quotient); end
    checks++; if (remainder !== 32'd5) begin errors++; $display("FAIL z_r got=%h want=00000005", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL z_dbz got=%b want=1", div_by_zero); end
    repeat (2) @(posedge clock); #1;
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL z_dbz_held got=%b want=1", div_by_zero); end
    issue_start(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_done(lat, bn);
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zs_q got=%h want=ffffffff", quotient); end
    checks++; if (remainder !== 32'hFFFF_FFFB) begin errors++; $display("FAIL zs_r got=%h want=fffffffb", remainder); end
    repeat (2) @(posedge clock);
    issue_start(1'b0, 32'd9, 32'd3);
    wait_done(lat, bn);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL z_dbz_cleared got=%b want=0", div_by_zero); end
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL z_next_q got=%h want=00000003", quotient); end
    repeat (2) @(posedge clock);
  endtask

  task automatic test_min_neg1();
    int lat, bn;
    issue_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("FAIL min_s_q got=%h want=80000000", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL min_s_r got=%h want=00000000", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL min_s_dbz got=%b want=0", div_by_zero); end
    repeat (2) @(posedge clock);
    issue_start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL min_u_q got=%h want=00000000", quotient); end
    checks++; if (remainder !== 32'h8000_0000) begin errors++; $display("FAIL min_u_r got=%h want=80000000", remainder); end
    repeat (2) @(posedge clock);
  endtask

  task automatic test_ignored_start();
    int first = -1;
    int pulses = 0;
    issue_start(1'b0, 32'd1000, 32'd10);
    for (int e = 1; e <= 60; e++) begin
      if (e == 10) begin
        start = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
    checks++; if (first !== Lat) begin errors++; $display("FAIL ign_latency got=%0d want=%0d", first, Lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ign_pulses got=%0d want=1", pulses); end
    checks++; if (quotient !== 32'd100) begin errors++; $display("FAIL ign_q got=%h want=00000064", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL ign_r got=%h want=00000000", remainder); end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    issue_start(1'b0, 32'd17, 32'd5);
    wait_done(lat, bn);
    // Request during the done cycle lands on the DONE edge and must be dropped.
    start = 1'b1;
    dividend = 32'd40;
    divisor = 32'd6;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drop_busy got=%b want=0", busy); end
    @(posedge clock); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL b2b_q_held got=%h want=00000003", quotient); end
    wait_done(lat, bn);
    checks++; if (lat !== Lat) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", lat, Lat); end
    checks++; if (quotient !== 32'd6) begin errors++; $display("FAIL b2b_q got=%h want=00000006", quotient); end
    checks++; if (remainder !== 32'd4) begin errors++; $display("FAIL b2b_r got=%h want=00000004", remainder); end
    repeat (2) @(posedge clock);
  endtask

  task automatic test_clear();
    int lat, bn;
    issue_start(1'b0, 32'd123, 32'd4);
    repeat (14) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done got=%b want=0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL clr_q got=%h want=0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL clr_r got=%h want=0", remainder); end
    @(negedge clock);
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_lost_op got=%b want=0", done); end
    issue_start(1'b0, 32'd9, 32'd3);
    wait_done(lat, bn);
    checks++; if (lat !== Lat) begin errors++; $display("FAIL clr_next_latency got=%0d want=%0d", lat, Lat); end
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL clr_next_q got=%h want=00000003", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL clr_next_r got=%h want=00000000", remainder); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_min_neg1();
    test_ignored_start();
    test_back_to_back();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential signed/unsigned integer divider for the CPU datapath's DIV instruction. It computes a quotient and remainder by repeated shift-and-subtract, retiring one quotient bit per clock. The quotient goes to LO and the remainder to HI. It sits beside the ALU's adder/subtractor path and uses a start/done handshake with the control unit.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start
- dividend  in  WIDTH  numerator; sampled with start
- divisor  in  WIDTH  denominator; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results are valid
- div_by_zero  out  1  valid with done; held until next accepted start
- quotient  out  WIDTH  LO result; held until next accepted start
- remainder  out  WIDTH  HI result; held until next accepted start

## Operation
- Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, state=IDLE, step counter=0.
- States:
  - IDLE: wait for start.
  - RUN: WIDTH iterations.
  - FIX: apply signs, write outputs.
  - DONE: single cycle, pulses done.
  - DONE returns to IDLE.
- IDLE, start=1: latch operands.
  - Signed mode: store magnitudes of the operands, plus quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign).
  - Clear the partial remainder (WIDTH+1 bits).
  - Go to RUN.
- RUN, each cycle:
  - Shift {partial remainder, working dividend} left by 1.
  - Trial = partial remainder − |divisor|.
  - If trial ≥ 0: keep trial and shift in quotient bit 1. Otherwise restore and shift in 0.
  - After WIDTH cycles, go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is set.
  - Negate the remainder if the remainder sign is set.
  - Register the results and go to DONE.
- Identity: the remainder has the dividend's sign and dividend = quotient·divisor + remainder (truncating division).
- Divisor = 0: the same state sequence and latency still run.
  - FIX forces quotient = all ones and remainder = original dividend.
  - div_by_zero=1.
- Signed MIN / −1: quotient = MIN (wraps), remainder = 0, no flag.
- start while busy or in DONE is ignored. No queuing.
- clear at any point, including mid-RUN, returns all state and outputs to reset values within the same cycle (async). The operation is lost.
- Widths:
  - Partial remainder is WIDTH+1 bits so the MIN magnitude is handled.
  - Magnitudes are computed unsigned.
  - Negation is two's-complement modulo 2^WIDTH.

## Timing
- Start accepted at rising edge T (IDLE, start=1).
- busy=1 during cycles T+1 … T+WIDTH+2.
- RUN occupies edges T+1 … T+WIDTH.
- FIX at edge T+WIDTH+1.
- done=1 for exactly the cycle after edge T+WIDTH+2 (WIDTH=32: 34 cycles after the start edge).
- Results are registered; they change only at the FIX edge and after clear.
- Next start is accepted in the cycle done is high only if the FSM is already in IDLE. It is not: the earliest start accepted is the edge after done deasserts.
- No combinational path from inputs to outputs.

## Structure
- Shared defines file holds:
  - FSM state encodings (IDLE, RUN, FIX, DONE; 2 bits)
  - default WIDTH
  - ALL_ONES constant per WIDTH
- One sub-module: div_step, a combinational shift/trial-subtract/select stage.
  - Inputs: partial remainder, dividend MSB, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside the iterative loop.
- Counter of $clog2(WIDTH)+1 bits counts RUN iterations.

## Test plan
- Unsigned 100 / 7, start pulse at T → done at T+34, quotient=14, remainder=2, div_by_zero=0, busy high for 34 cycles.
- Signed −7 / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Signed 7 / −2 → −3, 1.
- Any mode 5 / 0 → done at T+34, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. The next valid divide clears the flag.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned same operands → quotient=0, remainder=0x80000000.
- Second start (different operands) at T+10 during RUN → ignored. Results match the first operation. Exactly one done pulse.
- clear asserted at T+15 → busy, done, quotient, remainder are 0 immediately. After release, a new 9/3 completes with quotient=3, remainder=0 on schedule.
